// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit types, encoder FSM states and header field offsets
// Contents:
//   FLIT_HEAD/FLIT_BODY/FLIT_TAIL  2-bit flit type codes carried in flit[DATAW+1:DATAW]
//   enc_state_t                    packet encoder FSM state encoding
//   HDR_*_OFS                      header field offsets, counted down from the payload MSB
//   hdr_field_lsb()                converts an offset/width pair into an LSB index
package noc_pkg;

    localparam logic [1:0] FLIT_HEAD = 2'b10;
    localparam logic [1:0] FLIT_BODY = 2'b00;
    localparam logic [1:0] FLIT_TAIL = 2'b01;

    // CSUM is only entered when the checksum flit is built in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BODY  = 2'd1,
        DRAIN = 2'd2,
        CSUM  = 2'd3
    } enc_state_t;

    localparam int NOC_ADDRYX = 8;
    localparam int NOC_LENW   = 4;

    // HEAD layout from the MSB down: dest {Y,X}, src {Y,X}, len, zero fill.
    localparam int HDR_DEST_OFS = 0;
    localparam int HDR_SRC_OFS  = NOC_ADDRYX;
    localparam int HDR_LEN_OFS  = 2 * NOC_ADDRYX;

    function automatic int hdr_field_lsb(input int dataw, input int ofs, input int width);
        return dataw - ofs - width;
    endfunction

endpackage

// File: rtl/flit_out_reg.sv
// rtl/flit_out_reg.sv - single valid/ready holding register driving the router input channel
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   load_i            load load_flit_i this cycle (only when can_load_o)
//   load_flit_i [W]   next flit {type, payload}
//   can_load_o        register is empty or is being consumed this cycle
//   flit_o [W]        held flit
//   flit_valid_o      flit_o valid
//   flit_ready_i      router accepts flit when valid && ready
module flit_out_reg #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_flit_i,
    output logic         can_load_o,
    output logic [W-1:0] flit_o,
    output logic         flit_valid_o,
    input  logic         flit_ready_i
);

    // Reloading in the consume cycle keeps the channel at one flit per clock.
    assign can_load_o = !flit_valid_o || flit_ready_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flit_o       <= '0;
            flit_valid_o <= 1'b0;
        end else if (load_i) begin
            flit_o       <= load_flit_i;
            flit_valid_o <= 1'b1;
        end else if (flit_ready_i) begin
            flit_valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/packet_encoder.sv
// rtl/packet_encoder.sv - NoC injector: turns an IP send request plus payload words into HEAD/BODY/TAIL flits
// Optional feature: define PKT_CHECKSUM_EN to append a TAIL flit carrying the XOR of all body payloads.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   ip_req_i/ip_dest_i/ip_len_i    send request, destination {Y,X}, body words minus one
//   ip_ack_o                       one-cycle pulse when the request is accepted
//   ip_data_i/ip_data_valid_i      payload word stream from the IP
//   ip_data_ready_o                payload word taken when valid && ready
//   flit_o/flit_valid_o            {type[1:0], payload} to the router input
//   flit_ready_i                   router accepts a flit when valid && ready
//   busy_o                         packet in progress
module packet_encoder
    import noc_pkg::*;
#(
    parameter int               ADDRX   = 4,
    parameter int               ADDRY   = 4,
    parameter int               ADDRYX  = 8,
    parameter int               DATAW   = 32,
    parameter int               LENW    = 4,
    parameter logic [ADDRY-1:0] LOCAL_Y = 4'b0010,
    parameter logic [ADDRX-1:0] LOCAL_X = 4'b0010
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ip_req_i,
    input  logic [ADDRYX-1:0] ip_dest_i,
    input  logic [LENW-1:0]   ip_len_i,
    output logic              ip_ack_o,
    input  logic [DATAW-1:0]  ip_data_i,
    input  logic              ip_data_valid_i,
    output logic              ip_data_ready_o,
    output logic [DATAW+1:0]  flit_o,
    output logic              flit_valid_o,
    input  logic              flit_ready_i,
    output logic              busy_o
);

    enc_state_t        state;
    logic [LENW-1:0]   cnt;
    logic              load;
    logic [DATAW+1:0]  load_flit;
    logic              can_load;
    logic              take;
    logic [DATAW-1:0]  hdr;
`ifdef PKT_CHECKSUM_EN
    logic [DATAW-1:0]  csum;
`endif

    assign ip_data_ready_o = (state == BODY) && can_load;
    assign take            = ip_data_ready_o && ip_data_valid_i;
    assign busy_o          = (state != IDLE);

    always_comb begin
        hdr = '0;
        hdr[DATAW-1 -: ADDRYX]          = ip_dest_i;
        hdr[DATAW-1-ADDRYX -: ADDRYX]   = {LOCAL_Y, LOCAL_X};
        hdr[DATAW-1-2*ADDRYX -: LENW]   = ip_len_i;
    end

    // Output register is always empty in IDLE (DRAIN only exits on the consume),
    // so the HEAD can be loaded on the accept edge without checking can_load.
    always_comb begin
        load      = 1'b0;
        load_flit = '0;
        case (state)
            IDLE: begin
                if (ip_req_i) begin
                    load      = 1'b1;
                    load_flit = {FLIT_HEAD, hdr};
                end
            end
            BODY: begin
                if (take) begin
                    load = 1'b1;
`ifdef PKT_CHECKSUM_EN
                    load_flit = {FLIT_BODY, ip_data_i};
`else
                    load_flit = {(cnt == '0) ? FLIT_TAIL : FLIT_BODY, ip_data_i};
`endif
                end
            end
`ifdef PKT_CHECKSUM_EN
            CSUM: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_flit = {FLIT_TAIL, csum};
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ip_ack_o <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            ip_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (ip_req_i) begin
                        ip_ack_o <= 1'b1;
                        cnt      <= ip_len_i;
                        state    <= BODY;
`ifdef PKT_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                BODY: begin
                    if (take) begin
`ifdef PKT_CHECKSUM_EN
                        csum <= csum ^ ip_data_i;
`endif
                        // cnt holds at zero on the last word so len=15 never wraps.
                        if (cnt == '0) begin
`ifdef PKT_CHECKSUM_EN
                            state <= CSUM;
`else
                            state <= DRAIN;
`endif
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                CSUM: begin
                    if (can_load) state <= DRAIN;
                end
                DRAIN: begin
                    if (flit_valid_o && flit_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    flit_out_reg #(
        .W (DATAW + 2)
    ) u_flit_out_reg (
        .clk          (clk),
        .reset        (reset),
        .load_i       (load),
        .load_flit_i  (load_flit),
        .can_load_o   (can_load),
        .flit_o       (flit_o),
        .flit_valid_o (flit_valid_o),
        .flit_ready_i (flit_ready_i)
    );

endmodule

// File: tb/tb_packet_encoder.sv
// tb/tb_packet_encoder.sv - scoreboard bench for packet_encoder with randomized packets
module tb_packet_encoder;

    localparam int DATAW = 32;
`ifdef PKT_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              ip_req_i;
    logic [7:0]        ip_dest_i;
    logic [3:0]        ip_len_i;
    logic              ip_ack_o;
    logic [DATAW-1:0]  ip_data_i;
    logic              ip_data_valid_i;
    logic              ip_data_ready_o;
    logic [DATAW+1:0]  flit_o;
    logic              flit_valid_o;
    logic              flit_ready_i;
    logic              busy_o;

    always #5 clk = ~clk;

    packet_encoder dut (
        .clk             (clk),
        .reset           (reset),
        .ip_req_i        (ip_req_i),
        .ip_dest_i       (ip_dest_i),
        .ip_len_i        (ip_len_i),
        .ip_ack_o        (ip_ack_o),
        .ip_data_i       (ip_data_i),
        .ip_data_valid_i (ip_data_valid_i),
        .ip_data_ready_o (ip_data_ready_o),
        .flit_o          (flit_o),
        .flit_valid_o    (flit_valid_o),
        .flit_ready_i    (flit_ready_i),
        .busy_o          (busy_o)
    );

    logic [DATAW+1:0] exp_q[$];
    int               hs_cyc[$];
    int               cyc = 0;
    int               n_tests = 0;
    int               n_fail = 0;
    int               ack_cnt = 0;
    int               n_sent = 0;
    int               rdy_mode = 0;
    logic [31:0]      words[16];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", name, got, expv);
        end
    endtask

    // Reference model: a packet is the header word, then len+1 payload words,
    // the last tagged TAIL, or all BODY followed by an XOR TAIL when checksummed.
    task automatic push_model(input logic [7:0] dest, input logic [3:0] len);
        logic [31:0] hdr;
        logic [31:0] x;
        hdr = (32'(dest) << 24) | (32'(8'h22) << 16) | (32'(len) << 12);
        exp_q.push_back({2'b10, hdr});
        x = 0;
        for (int i = 0; i <= int'(len); i++) begin
            x = x ^ words[i];
            if (i == int'(len) && EXTRA == 0) exp_q.push_back({2'b01, words[i]});
            else                              exp_q.push_back({2'b00, words[i]});
        end
        if (EXTRA == 1) exp_q.push_back({2'b01, x});
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        flit_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       flit_ready_i = 1'b1;
                1:       flit_ready_i = ($urandom_range(0, 99) < 70);
                default: flit_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: every flit handshake is popped from the scoreboard and compared.
    initial forever begin
        logic [DATAW+1:0] e;
        @(negedge clk);
        if (reset && ip_ack_o) ack_cnt++;
        if (reset && flit_valid_o && flit_ready_i) begin
            hs_cyc.push_back(cyc);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_flit got=%0h expected=none", flit_o);
            end else begin
                e = exp_q.pop_front();
                if (flit_o !== e) begin
                    n_fail++;
                    $display("FAIL flit got=%0h expected=%0h", flit_o, e);
                end
            end
        end
    end

    // Starts and ends at posedge+1. Stops feeding after max_words accepted words.
    task automatic send(input logic [7:0] dest, input logic [3:0] len,
                        input int gap_pct, input int max_words);
        int n;
        int i;
        int guard;
        bit acked;
        bit took;
        n = int'(len) + 1;
        i = 0;
        guard = 0;
        acked = 0;
        n_sent++;
        push_model(dest, len);
        ip_req_i = 1'b1;
        ip_dest_i = dest;
        ip_len_i = len;
        ip_data_i = words[0];
        ip_data_valid_i = ($urandom_range(0, 99) >= gap_pct);
        while (i < n && i < max_words && guard < 2000) begin
            @(negedge clk);
            if (ip_ack_o) acked = 1;
            took = ip_data_valid_i && ip_data_ready_o;
            @(posedge clk);
            #1;
            guard++;
            if (took) i++;
            if (acked) ip_req_i = 1'b0;
            if (i < n) begin
                ip_data_i = words[i];
                ip_data_valid_i = ($urandom_range(0, 99) >= gap_pct);
            end else begin
                ip_data_valid_i = 1'b0;
            end
        end
        ip_data_valid_i = 1'b0;
        ip_req_i = 1'b0;
        if (guard >= 2000) check("send_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while (busy_o && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("idle_timeout", busy_o, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_words();
        for (int i = 0; i < 16; i++) words[i] = $urandom;
    endtask

    initial begin
        int g;
        logic [DATAW+1:0] held;
        reset = 1'b0;
        ip_req_i = 1'b0;
        ip_dest_i = '0;
        ip_len_i = '0;
        ip_data_i = '0;
        ip_data_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", {flit_o, flit_valid_o, ip_ack_o, ip_data_ready_o, busy_o}, 0);
        end
        @(posedge clk);
        #1;

        // dest 31, len 2, back-to-back
        rand_words();
        hs_cyc.delete();
        send(8'h31, 4'd2, 0, 16);
        wait_idle();
        check("t2_flit_count", hs_cyc.size(), 4 + EXTRA);
        if (hs_cyc.size() > 0)
            check("t2_back_to_back", hs_cyc[hs_cyc.size()-1] - hs_cyc[0], hs_cyc.size() - 1);

        // len 0
        rand_words();
        words[0] = 32'd5;
        g = ack_cnt;
        hs_cyc.delete();
        send(8'($urandom), 4'd0, 0, 16);
        wait_idle();
        check("t3_ack_once", ack_cnt - g, 1);
        check("t3_flit_count", hs_cyc.size(), 2 + EXTRA);

        // 5-cycle back-pressure mid-packet
        rand_words();
        hs_cyc.delete();
        fork
            send(8'h13, 4'd10, 0, 16);
            begin
                g = 0;
                while (hs_cyc.size() < 3 && g < 200) begin
                    @(negedge clk);
                    g++;
                end
                @(negedge clk);
                rdy_mode = 2;
                @(negedge clk);
                held = flit_o;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("t4_flit_stable", flit_o, held);
                    check("t4_valid_held", flit_valid_o, 1);
                    check("t4_data_ready_low", ip_data_ready_o, 0);
                end
                rdy_mode = 0;
            end
        join
        wait_idle();

        // reset in the middle of a len=15 packet
        rand_words();
        rdy_mode = 1;
        send(8'h44, 4'd15, 0, 5);
        #2;
        reset = 1'b0;
        #1;
        check("t5_valid_drop", flit_valid_o, 0);
        check("t5_busy_drop", busy_o, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        rdy_mode = 0;
        rand_words();
        hs_cyc.delete();
        send(8'h05, 4'd1, 0, 16);
        wait_idle();
        check("t5_clean_packet", hs_cyc.size(), 3 + EXTRA);

        // words 1, 2, 4
        words[0] = 32'd1;
        words[1] = 32'd2;
        words[2] = 32'd4;
        send(8'h21, 4'd2, 0, 16);
        wait_idle();

        // Randomized packets, including dest == local node and len 15
        rdy_mode = 1;
        for (int k = 0; k < 20; k++) begin
            logic [7:0] d;
            logic [3:0] l;
            rand_words();
            d = (k == 0) ? 8'h22 : 8'($urandom);
            l = (k == 1) ? 4'd15 : 4'($urandom);
            send(d, l, 30, 16);
            wait_idle();
        end

        check("acks_total", ack_cnt, n_sent);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
